// File: rtl/relogio_controle.sv
// Mode/timing controller for the digital clock: 1 Hz tick prescaler, button
// debounce, RUN/SET mode FSM, per-field increment pulses and blink enable.
module relogio_controle #(
  parameter int CLK_DIV         = 50000000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_DIV       = 25000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       sw_enable,
  output logic       tick,
  output logic [1:0] mode,
  output logic       inc_hour,
  output logic       inc_min,
  output logic       inc_sec,
  output logic       clr_sec,
  output logic       blink
);

  localparam int PS_W = $clog2(CLK_DIV);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BL_W = $clog2(BLINK_DIV + 1);

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_DIV - 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10,
    SET_SEC  = 2'b11
  } state_t;

  // Button bit 0 is key_mode, bit 1 is key_inc.
  logic [1:0]           sync1_q, sync1_d;
  logic [1:0]           sync2_q, sync2_d;
  logic [1:0]           db_q, db_d;
  logic [1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]           press_q, press_d;

  state_t          state_q, state_d;
  logic [PS_W-1:0] ps_cnt_q, ps_cnt_d;
  logic [BL_W-1:0] bl_cnt_q, bl_cnt_d;
  logic            tick_q, tick_d;
  logic            inc_hour_q, inc_hour_d;
  logic            inc_min_q, inc_min_d;
  logic            inc_sec_q, inc_sec_d;
  logic            clr_sec_q, clr_sec_d;
  logic            blink_q, blink_d;
  logic            mode_ev, inc_ev;

  // A press is flagged only on the debounced 1->0 update; releases are silent.
  always_comb begin
    sync1_d  = {key_inc, key_mode};
    sync2_d  = sync1_q;
    db_d     = db_q;
    db_cnt_d = '0;
    press_d  = '0;
    for (int b = 0; b < 2; b++) begin
      if (sync2_q[b] != db_q[b]) begin
        if (db_cnt_q[b] == DB_LAST) begin
          db_d[b]    = sync2_q[b];
          press_d[b] = ~sync2_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + DB_W'(1);
        end
      end
    end
  end

  // A mode event takes priority over an inc event arriving in the same cycle.
  always_comb begin
    mode_ev    = press_q[0] & sw_enable;
    inc_ev     = press_q[1] & sw_enable;
    state_d    = state_q;
    inc_hour_d = 1'b0;
    inc_min_d  = 1'b0;
    inc_sec_d  = 1'b0;
    clr_sec_d  = 1'b0;
    if (mode_ev) begin
      case (state_q)
        RUN:      state_d = SET_HOUR;
        SET_HOUR: state_d = SET_MIN;
        SET_MIN:  state_d = SET_SEC;
        default: begin
          state_d   = RUN;
          clr_sec_d = 1'b1;
        end
      endcase
    end else if (inc_ev) begin
      case (state_q)
        SET_HOUR: inc_hour_d = 1'b1;
        SET_MIN:  inc_min_d  = 1'b1;
        SET_SEC:  inc_sec_d  = 1'b1;
        default:  ;
      endcase
    end
  end

  // Prescaler runs only while staying in RUN, so any mode change restarts it.
  always_comb begin
    ps_cnt_d = '0;
    tick_d   = 1'b0;
    if (state_q == RUN && state_d == RUN) begin
      if (ps_cnt_q == PS_LAST) begin
        tick_d = 1'b1;
      end else begin
        ps_cnt_d = ps_cnt_q + PS_W'(1);
      end
    end
  end

  always_comb begin
    bl_cnt_d = '0;
    blink_d  = 1'b1;
    if (state_d != state_q) begin
      blink_d = (state_d == RUN);
    end else if (state_q != RUN) begin
      blink_d = blink_q;
      if (bl_cnt_q == BL_LAST) begin
        blink_d = ~blink_q;
      end else begin
        bl_cnt_d = bl_cnt_q + BL_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      db_q       <= 2'b11;
      db_cnt_q   <= '0;
      press_q    <= '0;
      state_q    <= RUN;
      ps_cnt_q   <= '0;
      bl_cnt_q   <= '0;
      tick_q     <= 1'b0;
      inc_hour_q <= 1'b0;
      inc_min_q  <= 1'b0;
      inc_sec_q  <= 1'b0;
      clr_sec_q  <= 1'b0;
      blink_q    <= 1'b1;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_q       <= db_d;
      db_cnt_q   <= db_cnt_d;
      press_q    <= press_d;
      state_q    <= state_d;
      ps_cnt_q   <= ps_cnt_d;
      bl_cnt_q   <= bl_cnt_d;
      tick_q     <= tick_d;
      inc_hour_q <= inc_hour_d;
      inc_min_q  <= inc_min_d;
      inc_sec_q  <= inc_sec_d;
      clr_sec_q  <= clr_sec_d;
      blink_q    <= blink_d;
    end
  end

  assign mode     = state_q;
  assign tick     = tick_q;
  assign inc_hour = inc_hour_q;
  assign inc_min  = inc_min_q;
  assign inc_sec  = inc_sec_q;
  assign clr_sec  = clr_sec_q;
  assign blink    = blink_q;

endmodule

// File: tb/tb_relogio_controle.sv
// Directed bench for relogio_controle with small divisors (10/4/5) and
// hand-computed expected cycle positions for every event.
module tb_relogio_controle;

  logic       clock = 1'b0;
  logic       reset;
  logic       key_mode;
  logic       key_inc;
  logic       sw_enable;
  logic       tick;
  logic [1:0] mode;
  logic       inc_hour;
  logic       inc_min;
  logic       inc_sec;
  logic       clr_sec;
  logic       blink;

  int n_compared   = 0;
  int n_mismatched = 0;

  int n_tick     = 0;
  int n_inc_hour = 0;
  int n_inc_min  = 0;
  int n_inc_sec  = 0;
  int n_clr_sec  = 0;
  int n_multi    = 0;

  relogio_controle #(
    .CLK_DIV        (10),
    .DEBOUNCE_CYCLES(4),
    .BLINK_DIV      (5)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .key_mode (key_mode),
    .key_inc  (key_inc),
    .sw_enable(sw_enable),
    .tick     (tick),
    .mode     (mode),
    .inc_hour (inc_hour),
    .inc_min  (inc_min),
    .inc_sec  (inc_sec),
    .clr_sec  (clr_sec),
    .blink    (blink)
  );

  always #5 clock = ~clock;

  // Pulse counters sampled mid-cycle; also flag any cycle with two pulses.
  always @(negedge clock) begin
    if (tick)     n_tick++;
    if (inc_hour) n_inc_hour++;
    if (inc_min)  n_inc_min++;
    if (inc_sec)  n_inc_sec++;
    if (clr_sec)  n_clr_sec++;
    if (int'(tick) + int'(inc_hour) + int'(inc_min) + int'(inc_sec) + int'(clr_sec) > 1)
      n_multi++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int got, input int exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic m, input logic i, input int cycles);
    key_mode = m;
    key_inc  = i;
    step(cycles);
  endtask

  // One clean press of 8 cycles followed by enough idle time for the release to settle.
  task automatic pressMode();
    applyStimulus(1'b0, 1'b1, 8);
    applyStimulus(1'b1, 1'b1, 10);
  endtask

  task automatic pressInc();
    applyStimulus(1'b1, 1'b0, 8);
    applyStimulus(1'b1, 1'b1, 10);
  endtask

  int snap_tick, snap_hour, snap_min, snap_sec, snap_clr;

  initial begin
    reset     = 1'b1;
    key_mode  = 1'b1;
    key_inc   = 1'b1;
    sw_enable = 1'b1;
    step(3);
    checkOutput("reset_mode",  int'(mode),  0);
    checkOutput("reset_blink", int'(blink), 1);
    checkOutput("reset_tick",  int'(tick),  0);
    checkOutput("reset_clr",   int'(clr_sec), 0);
    reset = 1'b0;

    // Free run: tick exactly on cycles 10, 20, 30, 40 after reset release.
    for (int c = 1; c <= 40; c++) begin
      step(1);
      checkOutput($sformatf("tick_free_c%0d", c), int'(tick), (c % 10 == 0) ? 1 : 0);
    end
    checkOutput("run_mode",  int'(mode),  0);
    checkOutput("run_blink", int'(blink), 1);

    // Short glitch must not register.
    applyStimulus(1'b0, 1'b1, 2);
    applyStimulus(1'b1, 1'b1, 10);
    checkOutput("glitch_mode", int'(mode), 0);

    // Real press: mode changes 6 edges after the first low sample.
    applyStimulus(1'b0, 1'b1, 6);
    checkOutput("press_early_mode", int'(mode), 0);
    step(1);
    checkOutput("press_mode", int'(mode), 1);
    checkOutput("press_blink0", int'(blink), 0);
    checkOutput("press_tick", int'(tick), 0);
    snap_tick = n_tick;
    key_mode  = 1'b1;
    step(4);
    checkOutput("blink_m4", int'(blink), 0);
    step(1);
    checkOutput("blink_m5", int'(blink), 1);
    step(4);
    checkOutput("blink_m9", int'(blink), 1);
    step(1);
    checkOutput("blink_m10", int'(blink), 0);
    step(10);

    // SET_MIN: three separate presses then one long hold, one pulse each.
    pressMode();
    checkOutput("setmin_mode", int'(mode), 2);
    snap_hour = n_inc_hour;
    snap_min  = n_inc_min;
    snap_sec  = n_inc_sec;
    for (int p = 0; p < 3; p++) pressInc();
    checkOutput("inc_min_x3", n_inc_min - snap_min, 3);
    applyStimulus(1'b1, 1'b0, 30);
    applyStimulus(1'b1, 1'b1, 10);
    checkOutput("inc_min_hold", n_inc_min - snap_min, 4);
    checkOutput("inc_hour_none", n_inc_hour - snap_hour, 0);
    checkOutput("inc_sec_none", n_inc_sec - snap_sec, 0);
    checkOutput("no_tick_in_set", n_tick - snap_tick, 0);

    // SET_SEC -> RUN: clr_sec with mode change, next tick 10 cycles later.
    pressMode();
    checkOutput("setsec_mode", int'(mode), 3);
    snap_clr = n_clr_sec;
    applyStimulus(1'b0, 1'b1, 7);
    checkOutput("back_run_mode", int'(mode), 0);
    checkOutput("back_run_clr", int'(clr_sec), 1);
    checkOutput("back_run_blink", int'(blink), 1);
    key_mode = 1'b1;
    step(1);
    checkOutput("clr_one_cycle", int'(clr_sec), 0);
    step(8);
    checkOutput("tick_m9", int'(tick), 0);
    step(1);
    checkOutput("tick_m10", int'(tick), 1);
    checkOutput("clr_count", n_clr_sec - snap_clr, 1);
    step(10);

    // Simultaneous mode/inc events in SET_HOUR: mode wins.
    pressMode();
    checkOutput("sethour_mode", int'(mode), 1);
    snap_hour = n_inc_hour;
    snap_min  = n_inc_min;
    applyStimulus(1'b0, 1'b0, 8);
    applyStimulus(1'b1, 1'b1, 10);
    checkOutput("simul_mode", int'(mode), 2);
    checkOutput("simul_no_hour", n_inc_hour - snap_hour, 0);
    checkOutput("simul_no_min", n_inc_min - snap_min, 0);

    // Buttons locked out.
    sw_enable = 1'b0;
    pressMode();
    pressInc();
    checkOutput("lock_mode", int'(mode), 2);
    checkOutput("lock_no_min", n_inc_min - snap_min, 0);
    sw_enable = 1'b1;

    // Reset while in SET_SEC with inc mid-debounce.
    pressMode();
    checkOutput("setsec2_mode", int'(mode), 3);
    snap_hour = n_inc_hour;
    snap_min  = n_inc_min;
    snap_sec  = n_inc_sec;
    applyStimulus(1'b1, 1'b0, 3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    checkOutput("rst_mid_mode", int'(mode), 0);
    checkOutput("rst_mid_blink", int'(blink), 1);
    checkOutput("rst_mid_sec", int'(inc_sec), 0);
    checkOutput("rst_mid_tick", int'(tick), 0);
    step(9);
    checkOutput("rst_tick_m9", int'(tick), 0);
    step(1);
    checkOutput("rst_tick_m10", int'(tick), 1);
    step(10);
    checkOutput("rst_after_mode", int'(mode), 0);
    checkOutput("rst_no_inc", (n_inc_hour - snap_hour) + (n_inc_min - snap_min) + (n_inc_sec - snap_sec), 0);
    applyStimulus(1'b1, 1'b1, 10);

    checkOutput("one_pulse_per_cycle", n_multi, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
